// File: rtl/otter_pipe_pkg.sv
// Shared types for the OTTER pipeline control blocks.
// The hazard controller's state encoding and the hard-wired zero register index.
package otter_pipe_pkg;

  typedef enum logic [0:0] {RUN, MEM_WAIT} hz_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that holds at MAX instead of wrapping.
// It has a synchronous clear, and rst takes priority over both clear and increment.
module sat_counter #(
  parameter int unsigned      WIDTH = 32,
  parameter logic [WIDTH-1:0] MAX   = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != MAX)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and stall controller for the OTTER 5-stage core.
// Handles load-use bubbles, taken-branch flushes and data-memory wait freezes with a watchdog.
module hazard_ctrl
  import otter_pipe_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       if_id_rs1,
  input  logic [4:0]       if_id_rs2,
  input  logic             if_id_uses_rs1,
  input  logic             if_id_uses_rs2,
  input  logic [4:0]       id_ex_rd,
  input  logic             id_ex_memRead,
  input  logic             ex_branch_taken,
  input  logic             ex_mem_memReq,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_flush,
  output logic             ex_mem_write,
  output logic             mem_wb_write,
  output logic             mem_timeout_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int unsigned         WAIT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0]   WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0]   WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  hz_state_t         state_q, state_d;
  logic              timeoutErr_q, timeoutErr_d;
  logic [WAIT_W-1:0] waitCnt;
  logic              loadUse;
  logic              memStall;
  logic              freeze;
  logic              waitClr;

  assign loadUse  = id_ex_memRead && (id_ex_rd != REG_ZERO) &&
                    ((if_id_uses_rs1 && (id_ex_rd == if_id_rs1)) ||
                     (if_id_uses_rs2 && (id_ex_rd == if_id_rs2)));
  assign memStall = ex_mem_memReq && !mem_ready;

  // While waiting, only mem_ready matters; the held branch/load-use is replayed on release.
  assign freeze  = (state_q == RUN) ? memStall : !mem_ready;
  assign waitClr = (state_q == MEM_WAIT) && mem_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      timeoutErr_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      timeoutErr_q <= timeoutErr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:      if (memStall)  state_d = MEM_WAIT;
      MEM_WAIT: if (mem_ready) state_d = RUN;
      default:                 state_d = RUN;
    endcase
  end

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_write  = 1'b1;
    id_ex_flush  = 1'b0;
    ex_mem_write = 1'b1;
    mem_wb_write = 1'b1;
    if (!rst) begin
      if (freeze) begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_write  = 1'b0;
        ex_mem_write = 1'b0;
        mem_wb_write = 1'b0;
      end else if (ex_branch_taken) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (loadUse) begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_ex_flush = 1'b1;
      end
    end
  end

  // Set on the edge where the wait counter lands on MEM_TIMEOUT, then hold until reset.
  assign timeoutErr_d   = timeoutErr_q || (freeze && (waitCnt >= WAIT_LAST));
  assign mem_timeout_err = timeoutErr_q;

  sat_counter #(.WIDTH(WAIT_W), .MAX(WAIT_MAX)) u_wait_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (freeze),
    .clr   (waitClr),
    .count (waitCnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (!pc_write),
    .clr   (1'b0),
    .count (stall_cycles)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (if_id_flush),
    .clr   (1'b0),
    .count (flush_count)
  );

endmodule
